regbank_access_sched: RTL and testbench

//  Owns an (M+1)-entry x N-bit register bank and shares it between NREQ requesters.

---
 rtl/regbank_access_sched.sv | 160 ++++++++++++++++
 tb/tb_regbank_access_sched.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regbank_access_sched.sv
// Register bank of M+1 N-bit entries shared by NREQ requesters, one access per grant, with an INIT clear sweep.
// Optional macro REGBANK_RR_FAIR_EN: round-robin arbitration; when undefined, fixed priority (lowest index wins).
module regbank_access_sched #(
    parameter int             N     = 4,
    parameter int             M     = 15,
    parameter int             NREQ  = 4,
    parameter logic [N-1:0]   VALUE = '0,
    parameter int             AW    = $clog2(M + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clr_i,
    input  logic [NREQ-1:0]         req_i,
    input  logic [NREQ-1:0]         we_i,
    input  logic [AW-1:0]           addr_i  [0:NREQ-1],
    input  logic [N-1:0]            wdata_i [0:NREQ-1],
    output logic [NREQ-1:0]         gnt_o,
    output logic                    rvalid_o,
    output logic [$clog2(NREQ)-1:0] rid_o,
    output logic [N-1:0]            rdata_o,
    output logic                    err_o,
    output logic                    busy_o,
    output logic [N-1:0]            rf_o [0:M]
);
    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {
        S_INIT   = 2'd0,
        S_IDLE   = 2'd1,
        S_ACCESS = 2'd2
    } state_e;

    state_e        state_q;
    logic [AW-1:0] ptr_q;
    logic [IW-1:0] gid_q;
    logic [N-1:0]  rf_q [0:M];

`ifdef REGBANK_RR_FAIR_EN
    logic [IW-1:0] rr_q;
`endif

    // Inputs of the requester currently holding the grant.
    logic          sel_req;
    logic          sel_we;
    logic          sel_bad;
    logic [AW-1:0] sel_addr;
    logic [N-1:0]  sel_wdata;

    assign sel_req   = req_i[gid_q];
    assign sel_we    = we_i[gid_q];
    assign sel_addr  = addr_i[gid_q];
    assign sel_wdata = wdata_i[gid_q];

    // A bank that fills the whole address space has no out-of-range index.
    generate
        if (M + 1 == (1 << AW)) begin : g_full_range
            assign sel_bad = 1'b0;
        end else begin : g_part_range
            assign sel_bad = (sel_addr > AW'(M));
        end
    endgenerate

    logic          win_vld;
    logic [IW-1:0] win_id;

    always_comb begin
        int cand;
        win_vld = 1'b0;
        win_id  = '0;
        cand    = 0;
        for (int i = 0; i < NREQ; i++) begin
`ifdef REGBANK_RR_FAIR_EN
            cand = (int'(rr_q) + i) % NREQ;
`else
            cand = i;
`endif
            if (!win_vld && req_i[cand]) begin
                win_vld = 1'b1;
                win_id  = IW'(cand);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_INIT;
            ptr_q    <= '0;
            gid_q    <= '0;
`ifdef REGBANK_RR_FAIR_EN
            rr_q     <= '0;
`endif
            gnt_o    <= '0;
            rvalid_o <= 1'b0;
            rid_o    <= '0;
            rdata_o  <= VALUE;
            err_o    <= 1'b0;
            busy_o   <= 1'b1;
        end else begin
            gnt_o    <= '0;
            rvalid_o <= 1'b0;
            err_o    <= 1'b0;
            case (state_q)
                S_INIT: begin
                    if (ptr_q == AW'(M)) begin
                        state_q <= S_IDLE;
                        ptr_q   <= '0;
                        busy_o  <= 1'b0;
                    end else begin
                        ptr_q <= ptr_q + AW'(1);
                    end
                end
                S_IDLE: begin
                    if (clr_i) begin
                        state_q <= S_INIT;
                        ptr_q   <= '0;
                        busy_o  <= 1'b1;
                    end else if (win_vld) begin
                        state_q <= S_ACCESS;
                        gid_q   <= win_id;
                        gnt_o   <= NREQ'(1) << win_id;
`ifdef REGBANK_RR_FAIR_EN
                        rr_q    <= IW'((int'(win_id) + 1) % NREQ);
`endif
                    end
                end
                S_ACCESS: begin
                    state_q <= S_IDLE;
                    // A requester that dropped req before this edge cancels its access.
                    if (sel_req) begin
                        err_o <= sel_bad;
                        if (!sel_we) begin
                            rvalid_o <= 1'b1;
                            rid_o    <= gid_q;
                            rdata_o  <= sel_bad ? VALUE : rf_q[sel_addr];
                        end
                    end
                end
                default: begin
                    state_q <= S_INIT;
                    ptr_q   <= '0;
                    busy_o  <= 1'b1;
                end
            endcase
        end
    end

    // Bank storage has no reset of its own; the INIT sweep clears it.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (state_q == S_INIT) begin
                rf_q[ptr_q] <= VALUE;
            end else if (state_q == S_ACCESS && sel_req && sel_we && !sel_bad) begin
                rf_q[sel_addr] <= sel_wdata;
            end
        end
    end

    assign rf_o = rf_q;

endmodule

// File: tb/tb_regbank_access_sched.sv
// Self-checking bench for regbank_access_sched: a default instance (M=15) plus an M=14 instance
// sharing the same inputs, used only where out-of-range addresses are exercised.
module tb_regbank_access_sched;
    localparam logic [3:0] VALUE = 4'h0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic [3:0] req = '0;
    logic [3:0] we  = '0;
    logic [3:0] addr_a  [0:3];
    logic [3:0] wdata_a [0:3];

    logic [3:0] gnt;
    logic       rvalid;
    logic [1:0] rid;
    logic [3:0] rdata;
    logic       err;
    logic       busy;
    logic [3:0] rf [0:15];

    logic [3:0] gnt14;
    logic       rvalid14;
    logic [1:0] rid14;
    logic [3:0] rdata14;
    logic       err14;
    logic       busy14;
    logic [3:0] rf14 [0:14];

    logic [3:0] model [0:15];
    logic [5:0] exp_q [$];
    int         cmp_cnt = 0;
    int         err_cnt = 0;

    regbank_access_sched u_dut (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .req_i(req), .we_i(we),
        .addr_i(addr_a), .wdata_i(wdata_a), .gnt_o(gnt), .rvalid_o(rvalid),
        .rid_o(rid), .rdata_o(rdata), .err_o(err), .busy_o(busy), .rf_o(rf)
    );

    regbank_access_sched #(.M(14)) u_dut14 (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .req_i(req), .we_i(we),
        .addr_i(addr_a), .wdata_i(wdata_a), .gnt_o(gnt14), .rvalid_o(rvalid14),
        .rid_o(rid14), .rdata_o(rdata14), .err_o(err14), .busy_o(busy14), .rf_o(rf14)
    );

    // Clock
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Scoreboard: every read pushes {rid, rdata}; each rvalid pops one.
    always @(negedge clk) begin
        if (rvalid === 1'b1) begin
            cmp_cnt++;
            if (exp_q.size() == 0) begin
                err_cnt++;
                $display("FAIL rvalid_unexpected: got rid=%0d rdata=%h, expected no read data", rid, rdata);
            end else begin
                logic [5:0] e;
                e = exp_q.pop_front();
                if ({rid, rdata} !== e) begin
                    err_cnt++;
                    $display("FAIL read_data: got rid=%0d rdata=%h, expected rid=%0d rdata=%h",
                             rid, rdata, e[5:4], e[3:0]);
                end
            end
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) model[i] = VALUE;
    endtask

    task automatic do_reset();
        int n;
        req = '0;
        clr = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n = 0;
        while (busy !== 1'b0 && n < 100) begin
            tick();
            n++;
        end
        cmp_cnt++;
        if (busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_sweep_timeout: busy=%b after %0d cycles, expected 0", busy, n);
        end
        model_clear();
    endtask

    // Raise a request, wait for its grant, then either keep it through the access edge or drop it.
    // Returns after the access edge; lat is the number of cycles from request to grant.
    task automatic do_access(input int id, input logic w, input logic [3:0] a, input logic [3:0] d,
                             input bit drop, output int lat);
        logic [3:0] oh;
        oh          = 4'b0001 << id;
        req[id]     = 1'b1;
        we[id]      = w;
        addr_a[id]  = a;
        wdata_a[id] = d;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (gnt[id] !== 1'b1 && lat < 50);
        cmp_cnt++;
        if (gnt !== oh) begin
            err_cnt++;
            $display("FAIL grant_onehot: gnt=%b, expected %b", gnt, oh);
        end
        if (drop) begin
            req[id] = 1'b0;
        end else if (!w) begin
            exp_q.push_back({2'(id), model[a]});
        end else begin
            model[a] = d;
        end
        tick();
        req[id] = 1'b0;
    endtask

    task automatic check_bank(input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < 16; i++) if (rf[i] !== model[i]) bad++;
        cmp_cnt++;
        if (bad != 0) begin
            err_cnt++;
            $display("FAIL %s: %0d entries differ, rf[0..3]=%h %h %h %h, expected %h %h %h %h",
                     name, bad, rf[0], rf[1], rf[2], rf[3], model[0], model[1], model[2], model[3]);
        end
    endtask

    // Scenarios
    task automatic test_reset();
        int cnt;
        tick();
        tick();
        cmp_cnt++;
        if ({busy, gnt, rvalid, err, rdata, rid} !== {1'b1, 4'b0, 1'b0, 1'b0, VALUE, 2'd0}) begin
            err_cnt++;
            $display("FAIL reset_outputs: busy=%b gnt=%b rvalid=%b err=%b rdata=%h rid=%0d, expected 1 0000 0 0 %h 0",
                     busy, gnt, rvalid, err, rdata, rid, VALUE);
        end
        rst = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 100) begin
            cnt++;
            tick();
        end
        cmp_cnt++;
        if (cnt != 16) begin
            err_cnt++;
            $display("FAIL init_busy_len: busy lasted %0d cycles, expected 16", cnt);
        end
        model_clear();
        check_bank("init_bank_cleared");
        cmp_cnt++;
        if (gnt !== 4'b0) begin
            err_cnt++;
            $display("FAIL init_gnt: gnt=%b, expected 0000", gnt);
        end
    endtask

    task automatic test_write_read();
        int lat;
        int id, a, d;
        do_access(0, 1'b1, 4'd3, 4'hA, 1'b0, lat);
        cmp_cnt++;
        if (rf[3] !== 4'hA) begin
            err_cnt++;
            $display("FAIL write_visible: rf[3]=%h, expected a", rf[3]);
        end
        do_access(0, 1'b0, 4'd3, 4'h0, 1'b0, lat);
        cmp_cnt++;
        if (lat != 1) begin
            err_cnt++;
            $display("FAIL grant_latency: %0d cycles, expected 1", lat);
        end
        cmp_cnt++;
        if ({rvalid, rid, rdata} !== {1'b1, 2'd0, 4'hA}) begin
            err_cnt++;
            $display("FAIL read_latency: rvalid=%b rid=%0d rdata=%h, expected 1 0 a", rvalid, rid, rdata);
        end
        for (int k = 0; k < 6; k++) begin
            id = $urandom_range(0, 3);
            a  = $urandom_range(0, 15);
            d  = $urandom_range(0, 15);
            do_access(id, 1'b1, 4'(a), 4'(d), 1'b0, lat);
            check_bank("random_write");
            do_access($urandom_range(0, 3), 1'b0, 4'(a), 4'h0, 1'b0, lat);
        end
    endtask

    task automatic test_arbitration();
        int lat, n, exp_id;
        logic [3:0] oh;
        do_reset();
        for (int i = 0; i < 4; i++) do_access(i, 1'b1, 4'(i), 4'(i + 8), 1'b0, lat);
        for (int i = 0; i < 4; i++) begin
            addr_a[i] = 4'(i);
            we[i]     = 1'b0;
        end
        req = 4'hF;
        for (int g = 0; g < 5; g++) begin
            n = 0;
            do begin
                tick();
                n++;
            end while (gnt === 4'b0 && n < 20);
`ifdef REGBANK_RR_FAIR_EN
            exp_id = g % 4;
`else
            exp_id = 0;
`endif
            oh = 4'b0001 << exp_id;
            cmp_cnt++;
            if (gnt !== oh) begin
                err_cnt++;
                $display("FAIL arb_order: grant %0d gnt=%b, expected %b", g, gnt, oh);
            end
            if (g > 0) begin
                cmp_cnt++;
                if (n != 2) begin
                    err_cnt++;
                    $display("FAIL arb_spacing: grant %0d after %0d cycles, expected 2", g, n);
                end
            end
            exp_q.push_back({2'(exp_id), model[exp_id]});
        end
        tick();
        req = '0;
    endtask

    task automatic test_out_of_range();
        int lat, bad;
        logic [3:0] snap [0:14];
        do_access(2, 1'b0, 4'd15, 4'h0, 1'b0, lat);
        cmp_cnt++;
        if ({rvalid14, rid14, rdata14, err14} !== {1'b1, 2'd2, VALUE, 1'b1}) begin
            err_cnt++;
            $display("FAIL oor_read: rvalid=%b rid=%0d rdata=%h err=%b, expected 1 2 %h 1",
                     rvalid14, rid14, rdata14, err14, VALUE);
        end
        cmp_cnt++;
        if (err !== 1'b0) begin
            err_cnt++;
            $display("FAIL inrange_err: err=%b on M=15 addr 15, expected 0", err);
        end
        snap = rf14;
        do_access(2, 1'b1, 4'd15, 4'h5, 1'b0, lat);
        cmp_cnt++;
        if ({err14, rvalid14} !== 2'b10) begin
            err_cnt++;
            $display("FAIL oor_write: err=%b rvalid=%b, expected 1 0", err14, rvalid14);
        end
        tick();
        bad = 0;
        for (int i = 0; i < 15; i++) if (rf14[i] !== snap[i]) bad++;
        cmp_cnt++;
        if (bad != 0) begin
            err_cnt++;
            $display("FAIL oor_bank: %0d entries changed, expected 0", bad);
        end
        check_bank("inrange_write15");
    endtask

    task automatic test_clear_vs_req();
        int lat, cnt;
        bit gnt_seen;
        do_access(3, 1'b1, 4'd9, 4'hC, 1'b0, lat);
        req[1] = 1'b1; we[1] = 1'b1; addr_a[1] = 4'd5; wdata_a[1] = 4'h7;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        cnt = 0;
        gnt_seen = 1'b0;
        while (busy === 1'b1 && cnt < 100) begin
            cnt++;
            if (gnt !== 4'b0) gnt_seen = 1'b1;
            tick();
        end
        cmp_cnt++;
        if (gnt_seen || cnt != 16) begin
            err_cnt++;
            $display("FAIL clear_sweep: busy %0d cycles, grant during sweep=%b, expected 16 and 0", cnt, gnt_seen);
        end
        tick();
        cmp_cnt++;
        if (gnt !== 4'b0010) begin
            err_cnt++;
            $display("FAIL clear_then_grant: gnt=%b, expected 0010", gnt);
        end
        tick();
        req[1] = 1'b0;
        model_clear();
        model[5] = 4'h7;
        check_bank("clear_bank");
    endtask

    task automatic test_reset_mid_sweep();
        int lat, cnt;
        do_access(0, 1'b1, 4'd6, 4'h9, 1'b0, lat);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 100) begin
            cnt++;
            tick();
        end
        cmp_cnt++;
        if (cnt != 16) begin
            err_cnt++;
            $display("FAIL midsweep_restart: busy lasted %0d cycles, expected 16", cnt);
        end
        model_clear();
        check_bank("midsweep_bank");
    endtask

    task automatic test_drop();
        int lat;
        do_access(0, 1'b1, 4'd2, 4'hF, 1'b1, lat);
        cmp_cnt++;
        if ({gnt, err, rvalid} !== 6'b0) begin
            err_cnt++;
            $display("FAIL drop_write_flags: gnt=%b err=%b rvalid=%b, expected 0000 0 0", gnt, err, rvalid);
        end
        tick();
        check_bank("drop_write_bank");
        do_access(1, 1'b0, 4'd4, 4'h0, 1'b1, lat);
        cmp_cnt++;
        if (rvalid !== 1'b0) begin
            err_cnt++;
            $display("FAIL drop_read: rvalid=%b, expected 0", rvalid);
        end
        do_access(2, 1'b1, 4'd4, 4'h6, 1'b0, lat);
        do_access(1, 1'b0, 4'd4, 4'h0, 1'b0, lat);
        cmp_cnt++;
        if ({rvalid, rid, rdata} !== {1'b1, 2'd1, 4'h6}) begin
            err_cnt++;
            $display("FAIL read_after_drop: rvalid=%b rid=%0d rdata=%h, expected 1 1 6", rvalid, rid, rdata);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            addr_a[i]  = '0;
            wdata_a[i] = '0;
        end
        test_reset();
        test_write_read();
        test_arbitration();
        test_out_of_range();
        test_clear_vs_req();
        test_reset_mid_sweep();
        test_drop();
        tick();
        tick();
        cmp_cnt++;
        if (exp_q.size() != 0) begin
            err_cnt++;
            $display("FAIL reads_outstanding: %0d reads never returned, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
